// File: rtl/riscv_csr_pkg.sv
// Shared M-mode CSR definitions: addresses, bit positions, Zicsr op encodings.
package riscv_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MEIE     = 11;
    localparam int MIP_MEIP     = 11;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;

endpackage

// File: rtl/irq_csr_unit_if.sv
// CSR-stage bus between the pipeline (master) and the interrupt/CSR unit (slave).
interface irq_csr_unit_if #(
    parameter int XLEN = 32
);
    logic            instr_valid;
    logic            stall;
    logic [XLEN-1:0] pc_in;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic            mret;
    logic [XLEN-1:0] csr_rdata;
    logic            trap_taken;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;

    modport master (
        output instr_valid, stall, pc_in, csr_op, csr_addr, csr_wdata, mret,
        input  csr_rdata, trap_taken, redirect, redirect_pc, flush
    );

    modport slave (
        input  instr_valid, stall, pc_in, csr_op, csr_addr, csr_wdata, mret,
        output csr_rdata, trap_taken, redirect, redirect_pc, flush
    );
endinterface

// File: rtl/irq_sync_edge.sv
// Interrupt pin synchroniser, registered rising-edge detector and pending latch.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    input  logic clr,
    output logic pending
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_q;

    // clr wins over a coincident edge: that request is dropped by design
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q <= sync_q[SYNC_STAGES-1];
            edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
            if (clr)
                pending <= 1'b0;
            else if (edge_q)
                pending <= 1'b1;
        end
    end
endmodule

// File: rtl/irq_csr_unit.sv
// Machine-mode interrupt/CSR unit: holds M-mode CSRs, raises trap/mret redirects.
module irq_csr_unit
    import riscv_csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = 'h40,
    parameter int              SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic interrupt,
    irq_csr_unit_if.slave bus
);
    logic            mie_q, mpie_q, meie_q, pending;
    logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q;
    logic [XLEN-1:0] rval, wval;
    logic            active, trap, mret_go, csr_we;
    csr_op_e         op;

    assign op      = csr_op_e'(bus.csr_op);
    assign active  = bus.instr_valid & ~bus.stall;
    assign trap    = pending & meie_q & mie_q & active & ~bus.mret;
    assign mret_go = active & bus.mret;
    assign csr_we  = active & (op != CSR_NONE) & ~trap;

    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .pin     (interrupt),
        .clr     (trap),
        .pending (pending)
    );

    always_comb begin
        rval = '0;
        case (bus.csr_addr)
            CSR_MSTATUS: begin
                rval[MSTATUS_MIE]  = mie_q;
                rval[MSTATUS_MPIE] = mpie_q;
            end
            CSR_MIE:    rval[MIE_MEIE] = meie_q;
            CSR_MIP:    rval[MIP_MEIP] = pending;
            CSR_MTVEC:  rval = mtvec_q;
            CSR_MEPC:   rval = mepc_q;
            CSR_MCAUSE: rval = mcause_q;
            default:    rval = '0;
        endcase
    end

    always_comb begin
        case (op)
            CSR_RW:  wval = bus.csr_wdata;
            CSR_RS:  wval = rval | bus.csr_wdata;
            CSR_RC:  wval = rval & ~bus.csr_wdata;
            default: wval = rval;
        endcase
    end

    assign bus.csr_rdata  = (op != CSR_NONE) ? rval : '0;
    assign bus.trap_taken = trap & ~rst;
    assign bus.redirect   = (trap | mret_go) & ~rst;
    assign bus.flush      = (trap | mret_go) & ~rst;

    // Interrupt outranks nothing here: trap already excludes the mret cycle
    always_comb begin
        bus.redirect_pc = '0;
        if (!rst) begin
            if (trap)
                bus.redirect_pc = {mtvec_q[XLEN-1:2], 2'b00};
            else if (mret_go)
                bus.redirect_pc = mepc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            meie_q   <= 1'b0;
            mtvec_q  <= {RESET_MTVEC[XLEN-1:2], 2'b00};
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            if (csr_we) begin
                case (bus.csr_addr)
                    CSR_MSTATUS: begin
                        mie_q  <= wval[MSTATUS_MIE];
                        mpie_q <= wval[MSTATUS_MPIE];
                    end
                    CSR_MIE:    meie_q   <= wval[MIE_MEIE];
                    CSR_MTVEC:  mtvec_q  <= {wval[XLEN-1:2], 2'b00};
                    CSR_MEPC:   mepc_q   <= {wval[XLEN-1:2], 2'b00};
                    CSR_MCAUSE: mcause_q <= wval;
                    default: ;
                endcase
            end
            if (trap) begin
                mepc_q   <= {bus.pc_in[XLEN-1:2], 2'b00};
                mcause_q <= XLEN'(MCAUSE_MEI);
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end else if (mret_go) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_irq_csr_unit.sv
// Directed bench for irq_csr_unit with a cycle-level reference model and per-cycle compare.
module tb_irq_csr_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic interrupt = 1'b0;
    always #5 clk = ~clk;

    irq_csr_unit_if #(.XLEN(32)) bus();

    irq_csr_unit #(.XLEN(32), .RESET_MTVEC(32'h40), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .interrupt (interrupt),
        .bus       (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: architectural CSR state plus a history of pin samples
    bit          m_mie, m_mpie, m_meie, m_pend;
    logic [31:0] m_mtvec, m_mepc, m_mcause;
    logic [7:0]  hist;

    function automatic logic [31:0] mread(logic [11:0] a);
        case (a)
            12'h300: return {24'b0, m_mpie, 3'b0, m_mie, 3'b0};
            12'h304: return {20'b0, m_meie, 11'b0};
            12'h344: return {20'b0, m_pend, 11'b0};
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit e_trap();
        return !rst && m_pend && m_meie && m_mie && bus.instr_valid && !bus.stall && !bus.mret;
    endfunction

    function automatic bit e_mret();
        return !rst && bus.instr_valid && !bus.stall && bus.mret;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit t, mr;
        logic [31:0] old, nw;
        if (rst) begin
            m_mie = 0; m_mpie = 0; m_meie = 0; m_pend = 0;
            m_mtvec = 32'h40; m_mepc = 0; m_mcause = 0;
            hist = 0;
        end else begin
            t = e_trap();
            mr = e_mret();
            if (bus.instr_valid && !bus.stall && bus.csr_op != 2'b00 && !t) begin
                old = mread(bus.csr_addr);
                nw = (bus.csr_op == 2'b01) ? bus.csr_wdata :
                     (bus.csr_op == 2'b10) ? (old | bus.csr_wdata) : (old & ~bus.csr_wdata);
                case (bus.csr_addr)
                    12'h300: begin m_mie = nw[3]; m_mpie = nw[7]; end
                    12'h304: m_meie = nw[11];
                    12'h305: m_mtvec = nw & 32'hFFFF_FFFC;
                    12'h341: m_mepc = nw & 32'hFFFF_FFFC;
                    12'h342: m_mcause = nw;
                    default: ;
                endcase
            end
            if (t) begin
                m_mepc = bus.pc_in & 32'hFFFF_FFFC;
                m_mcause = 32'h8000_000B;
                m_mpie = m_mie;
                m_mie = 0;
                m_pend = 0;
            end else begin
                if (mr) begin m_mie = m_mpie; m_mpie = 1; end
                // pin first seen high SYNC_STAGES+1 edges ago, low the edge before
                if (hist[2] && !hist[3]) m_pend = 1;
            end
            hist = {hist[6:0], interrupt};
        end
    end

    always @(negedge clk) begin
        bit et, em;
        et = e_trap();
        em = e_mret();
        chk("trap_taken", 32'(bus.trap_taken), 32'(et));
        chk("redirect", 32'(bus.redirect), 32'(et | em));
        chk("flush", 32'(bus.flush), 32'(et | em));
        if (et) chk("redirect_pc_trap", bus.redirect_pc, {m_mtvec[31:2], 2'b00});
        else if (em) chk("redirect_pc_mret", bus.redirect_pc, m_mepc);
        if (bus.csr_op != 2'b00) chk("csr_rdata", bus.csr_rdata, mread(bus.csr_addr));
    end

    task automatic drv(bit v, bit st, logic [31:0] pc, logic [1:0] op, logic [11:0] a,
                       logic [31:0] w, bit mr);
        bus.instr_valid = v; bus.stall = st; bus.pc_in = pc;
        bus.csr_op = op; bus.csr_addr = a; bus.csr_wdata = w; bus.mret = mr;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic csr(logic [1:0] op, logic [11:0] a, logic [31:0] w);
        drv(1, 0, 32'h100, op, a, w, 0);
        nxt();
    endtask

    task automatic rd(string name, logic [11:0] a, logic [31:0] exp);
        drv(1, 0, 32'h1000, 2'b10, a, 32'h0, 0);
        @(negedge clk);
        chk(name, bus.csr_rdata, exp);
        nxt();
    endtask

    task automatic do_mret(logic [31:0] exp_pc);
        drv(1, 0, 32'h0, 2'b00, 12'h0, 32'h0, 1);
        @(negedge clk);
        chk("mret_pc", bus.redirect_pc, exp_pc);
        chk("mret_no_trap", 32'(bus.trap_taken), 32'h0);
        nxt();
    endtask

    // Two-cycle pin pulse; reports trap count, first trap cycle and its target
    task automatic pulse_run(int n, bit v, logic [31:0] pc, output int tc, output int tf,
                             output logic [31:0] tpc);
        tc = 0; tf = -1; tpc = 32'h0;
        drv(v, 0, pc, 2'b00, 12'h0, 32'h0, 0);
        interrupt = 1'b1;
        for (int i = 1; i <= n; i++) begin
            nxt();
            if (i == 2) interrupt = 1'b0;
            @(negedge clk);
            if (bus.trap_taken) begin
                tc++;
                if (tf < 0) begin tf = i; tpc = bus.redirect_pc; end
            end
        end
        nxt();
    endtask

    initial begin
        int tc, tf;
        logic [31:0] tpc;
        drv(1, 0, 32'h0, 2'b01, 12'h305, 32'h0, 1);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_trap", 32'(bus.trap_taken), 32'h0);
        chk("rst_redirect", 32'(bus.redirect), 32'h0);
        chk("rst_flush", 32'(bus.flush), 32'h0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
        chk("rst_rdata_mtvec", bus.csr_rdata, 32'h40);
        nxt();
        nxt();
        rst = 1'b0;

        drv(1, 0, 32'h0, 2'b01, 12'h305, 32'h0, 0);
        @(negedge clk);
        chk("mtvec_reset", bus.csr_rdata, 32'h40);
        nxt();
        rd("mtvec_cleared", 12'h305, 32'h0);
        csr(2'b01, 12'h305, 32'h103);
        csr(2'b01, 12'h304, 32'h800);
        csr(2'b01, 12'h300, 32'h8);
        rd("mtvec_low_bits", 12'h305, 32'h100);
        rd("unimpl_addr", 12'h7C0, 32'h0);

        pulse_run(8, 1, 32'h24, tc, tf, tpc);
        chk("trap_count", tc, 32'd1);
        chk("trap_cycle", tf, 32'd4);
        chk("trap_target", tpc, 32'h100);
        rd("mepc_after_trap", 12'h341, 32'h24);
        rd("mcause_after_trap", 12'h342, 32'h8000_000B);
        rd("mstatus_after_trap", 12'h300, 32'h80);

        do_mret(32'h24);
        rd("mstatus_after_mret", 12'h300, 32'h88);

        csr(2'b01, 12'h300, 32'h0);
        pulse_run(8, 1, 32'h30, tc, tf, tpc);
        chk("masked_trap_count", tc, 32'd0);
        rd("mip_pending", 12'h344, 32'h800);
        drv(1, 0, 32'h34, 2'b10, 12'h300, 32'h8, 0);
        @(negedge clk);
        chk("set_mie_no_trap", 32'(bus.trap_taken), 32'h0);
        nxt();
        drv(1, 0, 32'h38, 2'b00, 12'h0, 32'h0, 0);
        @(negedge clk);
        chk("late_trap", 32'(bus.trap_taken), 32'h1);
        nxt();
        rd("mip_cleared", 12'h344, 32'h0);
        rd("mepc_late", 12'h341, 32'h38);

        do_mret(32'h38);
        pulse_run(6, 0, 32'h0, tc, tf, tpc);
        chk("bubble_trap_count", tc, 32'd0);
        do_mret(32'h38);
        drv(1, 0, 32'h40, 2'b00, 12'h0, 32'h0, 0);
        @(negedge clk);
        chk("trap_after_mret", 32'(bus.trap_taken), 32'h1);
        nxt();

        do_mret(32'h40);
        pulse_run(6, 0, 32'h0, tc, tf, tpc);
        drv(1, 0, 32'h58, 2'b01, 12'h341, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        chk("trap_with_csrrw", 32'(bus.trap_taken), 32'h1);
        nxt();
        rd("mepc_write_discarded", 12'h341, 32'h58);

        do_mret(32'h58);
        pulse_run(6, 0, 32'h0, tc, tf, tpc);
        drv(1, 1, 32'h60, 2'b10, 12'h344, 32'h0, 0);
        @(negedge clk);
        chk("stall_no_trap", 32'(bus.trap_taken), 32'h0);
        chk("mip_under_stall", bus.csr_rdata, 32'h800);
        nxt();
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drv(1, 0, 32'h64, 2'b00, 12'h0, 32'h0, 0);
            @(negedge clk);
            chk("no_redirect_after_rst", 32'(bus.redirect), 32'h0);
            nxt();
        end
        rd("mip_after_rst", 12'h344, 32'h0);
        rd("mstatus_after_rst", 12'h300, 32'h0);

        drv(0, 0, 32'h0, 2'b00, 12'h0, 32'h0, 0);
        nxt();
        nxt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
